// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store alignment unit:
//   - RISC-V funct3 size/sign codes (F3_B, F3_H, F3_W, F3_BU, F3_HU)
//   - FSM state enum (IDLE, SECOND)
//   - base_mask(): unshifted byte-lane mask for an access size
// -----------------------------------------------------------------------------
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic {
      IDLE   = 1'b0,
      SECOND = 1'b1
   } lsu_state_e;

   // Lanes touched by an access at offset 0. Only funct3[1:0] encodes size;
   // funct3[2] selects zero-extension for loads.
   function automatic logic [3:0] base_mask(input logic [2:0] funct3);
      logic [3:0] m;
      case (funct3[1:0])
         2'b00:   m = 4'b0001;
         2'b01:   m = 4'b0011;
         2'b10:   m = 4'b1111;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// -----------------------------------------------------------------------------
// lsu_load_extend
// Combinational load-result extension. The input word already has the
// addressed byte/halfword at bit 0.
// Ports:
//   i_data   in  32  lane-aligned load data
//   i_funct3 in  3   RISC-V funct3 (size/sign)
//   o_rdata  out 32  sign/zero-extended result (0 for unsupported codes)
// -----------------------------------------------------------------------------
module lsu_load_extend
   import lsu_pkg::*;
(
   input  logic [31:0] i_data,
   input  logic [2:0]  i_funct3,
   output logic [31:0] o_rdata
);

   always_comb begin
      case (i_funct3)
         F3_B:    o_rdata = {{24{i_data[7]}}, i_data[7:0]};
         F3_H:    o_rdata = {{16{i_data[15]}}, i_data[15:0]};
         F3_W:    o_rdata = i_data;
         F3_BU:   o_rdata = {24'b0, i_data[7:0]};
         F3_HU:   o_rdata = {16'b0, i_data[15:0]};
         default: o_rdata = 32'b0;
      endcase
   end

endmodule

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Load/store alignment unit in front of the data memory. Turns a byte address,
// funct3 and store data into a word address, lane-shifted write data and a
// byte mask; extracts and extends load data from the asynchronous read port.
// Accesses that straddle a word boundary take two memory cycles: the first
// cycle stalls the core and captures the low word, the second finishes.
//
// Optional build macro:
//   MISALIGN_TRAP_EN  - misaligned accesses raise o_misaligned instead of
//                       being split; nothing is written and no stall occurs.
//
// Ports:
//   i_clk, i_reset        clock, asynchronous active-high reset
//   i_req, i_we           access request, 1 = store
//   i_funct3              size/sign code
//   i_addr, i_wdata       byte address, LSB-justified store data
//   o_rdata               extended load result (0 for stores/idle)
//   o_stall               hold the core; access not finished
//   o_misaligned          misaligned trap (only with MISALIGN_TRAP_EN)
//   o_mem_addr            word-aligned memory address
//   o_mem_wdata           lane-shifted write data
//   o_mem_bmask           byte-lane mask
//   o_mem_wren            memory write enable
//   i_mem_rdata           asynchronous memory read data
// -----------------------------------------------------------------------------
module lsu_align
   import lsu_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_req,
   input  logic                  i_we,
   input  logic [2:0]            i_funct3,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [31:0]           i_wdata,
   output logic [31:0]           o_rdata,
   output logic                  o_stall,
   output logic                  o_misaligned,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   output logic [31:0]           o_mem_wdata,
   output logic [3:0]            o_mem_bmask,
   output logic                  o_mem_wren,
   input  logic [31:0]           i_mem_rdata
);

   lsu_state_e state_q, state_d;
   logic [31:0] lo_buf_q, lo_buf_d;

   logic [1:0]            off;
   logic                  legal;
   logic                  mis;
   logic                  active;
   logic                  crossing;
   logic [7:0]            mask8;
   logic [63:0]           data64;
   logic [ADDR_WIDTH-1:0] addr_lo;
   logic [ADDR_WIDTH-1:0] addr_hi;
   logic [ADDR_WIDTH-3:0] word_idx_p1;
   logic [31:0]           ext_in;
   logic [31:0]           ext_out;
   logic                  load_en;

   assign off = i_addr[1:0];

   // Unsigned loads have no store counterpart.
   always_comb begin
      case (i_funct3)
         F3_B, F3_H, F3_W: legal = 1'b1;
         F3_BU, F3_HU:     legal = ~i_we;
         default:          legal = 1'b0;
      endcase
   end

`ifdef MISALIGN_TRAP_EN
   always_comb begin
      mis = 1'b0;
      if (i_req && legal) begin
         case (i_funct3[1:0])
            2'b01:   mis = off[0];
            2'b10:   mis = |off;
            default: mis = 1'b0;
         endcase
      end
   end
`else
   assign mis = 1'b0;
`endif

   assign active   = i_req & legal & ~mis;
   assign mask8    = {4'b0000, base_mask(i_funct3)} << off;
   assign data64   = {32'b0, i_wdata} << {off, 3'b000};
   assign crossing = |mask8[7:4];

   // Upper word address wraps modulo 2^ADDR_WIDTH.
   assign word_idx_p1 = i_addr[ADDR_WIDTH-1:2] + {{(ADDR_WIDTH-3){1'b0}}, 1'b1};
   assign addr_lo     = {i_addr[ADDR_WIDTH-1:2], 2'b00};
   assign addr_hi     = {word_idx_p1, 2'b00};

   // State register and low-word buffer
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q  <= IDLE;
         lo_buf_q <= 32'b0;
      end else begin
         state_q  <= state_d;
         lo_buf_q <= lo_buf_d;
      end
   end

   // Next state
   always_comb begin
      state_d  = state_q;
      lo_buf_d = lo_buf_q;
      case (state_q)
         IDLE: begin
            if (active && crossing) begin
               state_d  = SECOND;
               lo_buf_d = i_mem_rdata;
            end
         end
         SECOND:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      o_mem_addr  = addr_lo;
      o_mem_wdata = data64[31:0];
      o_mem_bmask = 4'b0000;
      o_mem_wren  = 1'b0;
      o_stall     = 1'b0;
      load_en     = 1'b0;
      ext_in      = i_mem_rdata >> {off, 3'b000};
      case (state_q)
         IDLE: begin
            if (active) begin
               o_mem_bmask = mask8[3:0];
               o_mem_wren  = i_we;
               o_stall     = crossing;
               load_en     = ~i_we;
            end
         end
         SECOND: begin
            o_mem_addr  = addr_hi;
            o_mem_wdata = data64[63:32];
            // Splice the high bytes of the low word with the low bytes of
            // the high word; offset 0 never crosses.
            case (off)
               2'd1:    ext_in = {i_mem_rdata[7:0],  lo_buf_q[31:8]};
               2'd2:    ext_in = {i_mem_rdata[15:0], lo_buf_q[31:16]};
               2'd3:    ext_in = {i_mem_rdata[23:0], lo_buf_q[31:24]};
               default: ext_in = lo_buf_q;
            endcase
            // A dropped request here is a protocol violation: just finish.
            if (active) begin
               o_mem_bmask = mask8[7:4];
               o_mem_wren  = i_we;
               load_en     = ~i_we;
            end
         end
         default: ;
      endcase
      // Reset is asynchronous, so the outputs are forced quiet at once
      // rather than waiting for the state register to settle.
      if (i_reset) begin
         o_mem_bmask = 4'b0000;
         o_mem_wren  = 1'b0;
         o_stall     = 1'b0;
         load_en     = 1'b0;
      end
   end

   lsu_load_extend u_ext (
      .i_data   (ext_in),
      .i_funct3 (i_funct3),
      .o_rdata  (ext_out)
   );

   assign o_rdata      = load_en ? ext_out : 32'b0;
   assign o_misaligned = mis & ~i_reset;

endmodule

// File: tb/tb_lsu_align.sv
module tb_lsu_align;
   import lsu_pkg::*;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        i_req;
   logic        i_we;
   logic [2:0]  i_funct3;
   logic [31:0] i_addr;
   logic [31:0] i_wdata;
   logic [31:0] o_rdata;
   logic        o_stall;
   logic        o_misaligned;
   logic [31:0] o_mem_addr;
   logic [31:0] o_mem_wdata;
   logic [3:0]  o_mem_bmask;
   logic        o_mem_wren;
   logic [31:0] i_mem_rdata;

   logic [31:0] mem [0:1023];

   int total = 0;
   int bad   = 0;

   always #5 i_clk = ~i_clk;

   lsu_align #(.ADDR_WIDTH(32)) dut (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_req        (i_req),
      .i_we         (i_we),
      .i_funct3     (i_funct3),
      .i_addr       (i_addr),
      .i_wdata      (i_wdata),
      .o_rdata      (o_rdata),
      .o_stall      (o_stall),
      .o_misaligned (o_misaligned),
      .o_mem_addr   (o_mem_addr),
      .o_mem_wdata  (o_mem_wdata),
      .o_mem_bmask  (o_mem_bmask),
      .o_mem_wren   (o_mem_wren),
      .i_mem_rdata  (i_mem_rdata)
   );

   // Word memory, 4 KiB window, asynchronous read, byte-masked write.
   assign i_mem_rdata = mem[o_mem_addr[11:2]];
   always @(posedge i_clk) begin
      if (o_mem_wren) begin
         for (int b = 0; b < 4; b++)
            if (o_mem_bmask[b]) mem[o_mem_addr[11:2]][8*b +: 8] <= o_mem_wdata[8*b +: 8];
      end
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", tag, act, exp);
      end
   endtask

   // Apply inputs just after a rising edge, then let combinational paths settle.
   task automatic drive(input logic req, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
      i_req    = req;
      i_we     = we;
      i_funct3 = f3;
      i_addr   = addr;
      i_wdata  = wd;
      #2;
   endtask

   task automatic cyc();
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      i_reset = 1'b1;
      // Outputs must stay quiet under reset even with a crossing store pending.
      drive(1'b1, 1'b1, F3_W, 32'h0000_00FE, 32'h1122_3344);
      chk("rst_stall", 32'(o_stall), 32'h0);
      chk("rst_wren",  32'(o_mem_wren), 32'h0);
      chk("rst_bmask", 32'(o_mem_bmask), 32'h0);
      chk("rst_mis",   32'(o_misaligned), 32'h0);
      chk("rst_rdata", o_rdata, 32'h0);
      cyc();
      cyc();
      i_reset = 1'b0;
      drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
      chk("idle_bmask", 32'(o_mem_bmask), 32'h0);
      chk("idle_wren",  32'(o_mem_wren), 32'h0);
      chk("idle_rdata", o_rdata, 32'h0);
      cyc();

      // SW / LW aligned
      drive(1'b1, 1'b1, F3_W, 32'h0000_0100, 32'hDEAD_BEEF);
      chk("sw_addr",  o_mem_addr, 32'h0000_0100);
      chk("sw_bmask", 32'(o_mem_bmask), 32'hF);
      chk("sw_wdata", o_mem_wdata, 32'hDEAD_BEEF);
      chk("sw_wren",  32'(o_mem_wren), 32'h1);
      chk("sw_stall", 32'(o_stall), 32'h0);
      cyc();
      drive(1'b1, 1'b0, F3_W, 32'h0000_0100, 32'h0);
      chk("lw_rdata", o_rdata, 32'hDEAD_BEEF);
      chk("lw_wren",  32'(o_mem_wren), 32'h0);
      chk("lw_stall", 32'(o_stall), 32'h0);
      cyc();

      // SB / LB / LBU at lane 3
      drive(1'b1, 1'b1, F3_B, 32'h0000_0103, 32'h0000_00A5);
      chk("sb_bmask", 32'(o_mem_bmask), 32'h8);
      chk("sb_wdata", o_mem_wdata, 32'hA500_0000);
      cyc();
      drive(1'b1, 1'b0, F3_B, 32'h0000_0103, 32'h0);
      chk("lb_rdata", o_rdata, 32'hFFFF_FFA5);
      cyc();
      drive(1'b1, 1'b0, F3_BU, 32'h0000_0103, 32'h0);
      chk("lbu_rdata", o_rdata, 32'h0000_00A5);
      cyc();
      drive(1'b1, 1'b0, F3_W, 32'h0000_0100, 32'h0);
      chk("sb_merge", o_rdata, 32'hA5AD_BEEF);
      cyc();

      // LH / LHU upper half
      drive(1'b1, 1'b1, F3_W, 32'h0000_0100, 32'h8001_7F00);
      cyc();
      drive(1'b1, 1'b0, F3_H, 32'h0000_0102, 32'h0);
      chk("lh_rdata", o_rdata, 32'hFFFF_8001);
      chk("lh_stall", 32'(o_stall), 32'h0);
      cyc();
      drive(1'b1, 1'b0, F3_HU, 32'h0000_0102, 32'h0);
      chk("lhu_rdata", o_rdata, 32'h0000_8001);
      cyc();

      // Illegal codes
      drive(1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0);
      chk("ill_ld_bmask", 32'(o_mem_bmask), 32'h0);
      chk("ill_ld_rdata", o_rdata, 32'h0);
      cyc();
      drive(1'b1, 1'b1, F3_BU, 32'h0000_0100, 32'hFFFF_FFFF);
      chk("ill_st_wren",  32'(o_mem_wren), 32'h0);
      chk("ill_st_bmask", 32'(o_mem_bmask), 32'h0);
      chk("ill_st_stall", 32'(o_stall), 32'h0);
      cyc();

`ifdef MISALIGN_TRAP_EN
      drive(1'b1, 1'b0, F3_W, 32'h0000_0102, 32'h0);
      chk("trap_mis",   32'(o_misaligned), 32'h1);
      chk("trap_wren",  32'(o_mem_wren), 32'h0);
      chk("trap_stall", 32'(o_stall), 32'h0);
      chk("trap_rdata", o_rdata, 32'h0);
      cyc();
      drive(1'b1, 1'b1, F3_H, 32'h0000_0101, 32'h0000_BEEF);
      chk("trap_sh_mis",   32'(o_misaligned), 32'h1);
      chk("trap_sh_bmask", 32'(o_mem_bmask), 32'h0);
      cyc();
      drive(1'b1, 1'b0, F3_W, 32'h0000_0100, 32'h0);
      chk("trap_nowrite", o_rdata, 32'h8001_7F00);
      cyc();
`else
      // Crossing SW across 0x0FC/0x100
      drive(1'b1, 1'b1, F3_W, 32'h0000_00FE, 32'h1122_3344);
      chk("xsw1_addr",  o_mem_addr, 32'h0000_00FC);
      chk("xsw1_bmask", 32'(o_mem_bmask), 32'hC);
      chk("xsw1_wdata", o_mem_wdata, 32'h3344_0000);
      chk("xsw1_stall", 32'(o_stall), 32'h1);
      chk("xsw1_mis",   32'(o_misaligned), 32'h0);
      cyc();
      chk("xsw2_addr",  o_mem_addr, 32'h0000_0100);
      chk("xsw2_bmask", 32'(o_mem_bmask), 32'h3);
      chk("xsw2_wdata", o_mem_wdata, 32'h0000_1122);
      chk("xsw2_wren",  32'(o_mem_wren), 32'h1);
      chk("xsw2_stall", 32'(o_stall), 32'h0);
      cyc();

      // Crossing LW reads it back
      drive(1'b1, 1'b0, F3_W, 32'h0000_00FE, 32'h0);
      chk("xlw1_stall", 32'(o_stall), 32'h1);
      chk("xlw1_wren",  32'(o_mem_wren), 32'h0);
      cyc();
      chk("xlw2_rdata", o_rdata, 32'h1122_3344);
      chk("xlw2_stall", 32'(o_stall), 32'h0);
      cyc();
      drive(1'b1, 1'b0, F3_W, 32'h0000_0100, 32'h0);
      chk("xsw_hi_word", o_rdata, 32'h8001_1122);
      cyc();

      // Crossing LH at offset 3: lane 3 of 0x0FC (0x33) + lane 0 of 0x100 (0x22)
      drive(1'b1, 1'b0, F3_H, 32'h0000_00FF, 32'h0);
      chk("xlh1_stall", 32'(o_stall), 32'h1);
      cyc();
      chk("xlh2_rdata", o_rdata, 32'h0000_2233);
      cyc();

      // Non-crossing misaligned LH completes in one cycle: lanes 1,2 = 0x11,0x01
      drive(1'b1, 1'b0, F3_H, 32'h0000_0101, 32'h0);
      chk("mlh_rdata", o_rdata, 32'h0000_0111);
      chk("mlh_stall", 32'(o_stall), 32'h0);
      cyc();

      // Misaligned LW splits when trapping is disabled
      drive(1'b1, 1'b0, F3_W, 32'h0000_0102, 32'h0);
      chk("mlw1_stall", 32'(o_stall), 32'h1);
      chk("mlw1_mis",   32'(o_misaligned), 32'h0);
      cyc();
      chk("mlw2_addr",  o_mem_addr, 32'h0000_0104);
      chk("mlw2_stall", 32'(o_stall), 32'h0);
      cyc();

      // Address wrap on the second half
      drive(1'b1, 1'b1, F3_W, 32'hFFFF_FFFD, 32'hCAFE_F00D);
      chk("wrap1_addr",  o_mem_addr, 32'hFFFF_FFFC);
      chk("wrap1_bmask", 32'(o_mem_bmask), 32'hE);
      chk("wrap1_wdata", o_mem_wdata, 32'hFEF0_0D00);
      cyc();
      chk("wrap2_addr",  o_mem_addr, 32'h0000_0000);
      chk("wrap2_bmask", 32'(o_mem_bmask), 32'h1);
      chk("wrap2_wdata", o_mem_wdata, 32'h0000_00CA);
      cyc();
      drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
      chk("wrap_mem0", 32'(mem[0][7:0]), 32'h0000_00CA);

      // Request dropped during SECOND: no second write, back to IDLE
      drive(1'b1, 1'b1, F3_W, 32'h0000_0301, 32'h0102_0304);
      chk("drop1_stall", 32'(o_stall), 32'h1);
      cyc();
      drive(1'b0, 1'b1, F3_W, 32'h0000_0301, 32'h0102_0304);
      chk("drop2_wren",  32'(o_mem_wren), 32'h0);
      chk("drop2_bmask", 32'(o_mem_bmask), 32'h0);
      cyc();
      drive(1'b1, 1'b0, F3_W, 32'h0000_0300, 32'h0);
      chk("drop_idle", 32'(o_stall), 32'h0);
      cyc();

      // Reset while in SECOND of a crossing store
      drive(1'b1, 1'b1, F3_W, 32'h0000_0200, 32'hAABB_CCDD);
      cyc();
      drive(1'b1, 1'b1, F3_W, 32'h0000_0204, 32'h5566_7788);
      cyc();
      drive(1'b1, 1'b1, F3_W, 32'h0000_0202, 32'h1122_3344);
      chk("rs1_stall", 32'(o_stall), 32'h1);
      cyc();
      i_reset = 1'b1;
      #1;
      chk("rs_stall", 32'(o_stall), 32'h0);
      chk("rs_wren",  32'(o_mem_wren), 32'h0);
      chk("rs_bmask", 32'(o_mem_bmask), 32'h0);
      chk("rs_mis",   32'(o_misaligned), 32'h0);
      chk("rs_rdata", o_rdata, 32'h0);
      i_req = 1'b0;
      cyc();
      cyc();
      i_reset = 1'b0;
      drive(1'b1, 1'b0, F3_W, 32'h0000_0204, 32'h0);
      chk("rs_hi_kept",  o_rdata, 32'h5566_7788);
      chk("rs_idle",     32'(o_stall), 32'h0);
      cyc();
      drive(1'b1, 1'b0, F3_W, 32'h0000_0200, 32'h0);
      chk("rs_lo_written", o_rdata, 32'h3344_CCDD);
      cyc();
`endif

      drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
      cyc();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lsu_align.md
Name: lsu_align

Overview:
- Load/store alignment unit sitting directly upstream of the data memory in the single-cycle RISC-V core.
- Converts core byte addresses, funct3 and store data into word-aligned memory address, shifted write data and 4-bit byte mask.
- Extracts, aligns and sign/zero-extends load data from the memory's asynchronous read port.
- Splits word-boundary-crossing accesses into two memory cycles via a small FSM, stalling the core for one cycle.

Parameters:
- ADDR_WIDTH, 32, width of core and memory byte addresses.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  asynchronous active-high reset
- i_req  in  1  core requests a load/store this cycle
- i_we  in  1  1 = store, 0 = load
- i_funct3  in  3  RISC-V funct3 (size/sign)
- i_addr  in  ADDR_WIDTH  byte address from ALU
- i_wdata  in  32  store data (rs2), LSB-justified
- o_rdata  out  32  extended load result to writeback
- o_stall  out  1  hold PC/pipeline; access not yet complete
- o_misaligned  out  1  misaligned-access trap (only with MISALIGN_TRAP_EN)
- o_mem_addr  out  ADDR_WIDTH  word-aligned address to memory
- o_mem_wdata  out  32  lane-shifted write data
- o_mem_bmask  out  4  byte mask, bit n = byte lane n
- o_mem_wren  out  1  memory write enable
- i_mem_rdata  in  32  asynchronous memory read data

Behaviour:
- Clock/reset: one clock i_clk; i_reset is asynchronous, active-high. Reset forces state to IDLE and clears the low-word buffer to 0.
- Outputs during reset: o_stall=0, o_mem_wren=0, o_mem_bmask=0, o_misaligned=0, o_rdata=0.
- Sizes: funct3 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
  - Other codes, or funct3 1xx with i_we=1, are illegal: no write, bmask=0, o_rdata=0, no stall.
- Base mask: byte=0001, half=0011, word=1111; off=i_addr[1:0].
  - mask8 = base<<off (8-bit).
  - data64 = {32'b0,i_wdata}<<(8*off).
- Crossing condition: mask8[7:4]!=0, i.e. half with off=3, or word with off!=0.
- FSM states IDLE and SECOND.
- IDLE, non-crossing access (combinational, zero added latency):
  - o_mem_addr={i_addr[AW-1:2],2'b00}; o_mem_bmask=mask8[3:0]; o_mem_wdata=data64[31:0]; o_mem_wren=i_req&i_we.
  - Load: o_rdata=extend((i_mem_rdata>>8*off)).
- IDLE, crossing access:
  - First memory cycle as above (writes the low part); o_stall=1.
  - Register i_mem_rdata into buf; next state SECOND.
- SECOND:
  - o_mem_addr=aligned+4, modulo 2^ADDR_WIDTH (0xFFFFFFFD -> 0x00000000).
  - o_mem_bmask=mask8[7:4]; o_mem_wdata=data64[63:32]; o_mem_wren=i_we.
  - Load: o_rdata=extend(({i_mem_rdata,buf}>>8*off)[31:0]).
  - o_stall=0; next state IDLE.
- extend(): LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes through.
- Core holds i_req/i_we/i_funct3/i_addr/i_wdata stable while o_stall=1. The unit uses live inputs in SECOND; no input latching except buf.
- i_req=0 in IDLE: bmask=0, wren=0, o_rdata=0, stay IDLE.
- i_req dropping in SECOND is a protocol violation: return to IDLE, no write.
- Reset mid-SECOND: the second half is not written; the first half write stands.
- o_rdata is don't-care for stores; driven 0.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined:
  - Any access with off not a multiple of the size raises o_misaligned=1 combinationally.
  - Forces wren=0, bmask=0, o_rdata=0 and never enters SECOND; o_stall stays 0.
- Undefined:
  - o_misaligned tied 0; misaligned accesses handled in hardware as above.
  - Non-crossing misaligned accesses (e.g. LH at off=1) complete in one cycle.

Decomposition:
- Package lsu_pkg holds:
  - funct3 localparams/enum (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - state enum {IDLE, SECOND};
  - base-mask function.
- Sub-module lsu_load_extend: combinational, inputs 32-bit aligned data and funct3, outputs extended o_rdata. Reused by both FSM states.

Test Plan:
- SW 0xDEADBEEF @0x100 -> one cycle, addr 0x100, bmask 1111, wdata 0xDEADBEEF, no stall.
  - Then LW @0x100 -> o_rdata 0xDEADBEEF.
- SB 0x000000A5 @0x103 -> bmask 1000, wdata 0xA5000000.
  - LB @0x103 -> 0xFFFFFFA5; LBU -> 0x000000A5.
- LH @0x102 with mem[0x100]=0x80017F00 -> o_rdata 0xFFFF8001, single cycle.
- SW 0x11223344 @0x0FE:
  - cycle 1 addr 0x0FC, bmask 1100, wdata 0x33440000, stall=1;
  - cycle 2 addr 0x100, bmask 0011, wdata 0x00001122, stall=0.
  - LW @0x0FE -> 0x11223344 after 2 cycles.
- Assert i_reset during SECOND of a crossing store -> state IDLE immediately, second-half write absent, all outputs at reset values.
- With MISALIGN_TRAP_EN, LW @0x102 -> o_misaligned=1, wren=0, stall=0.
  - Without the macro, the same access splits into two cycles.
